// File: rtl/soc_bb_sram_arbiter.sv
// Round-robin arbiter sharing one BB single-port SRAM among NM requesters,
// with a per-requester lock for atomic sequences and a fixed-latency read return.
module soc_bb_sram_arbiter #(
    parameter int NM     = 4,
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic             bb_clk_i,
    input  logic             bb_rst_i,
    input  logic [NM-1:0]    req_i,
    input  logic [NM-1:0]    we_i,
    input  logic [NM-1:0]    lock_i,
    input  logic [NM*AW-1:0] addr_i,
    input  logic [NM*DW-1:0] din_i,
    output logic [NM-1:0]    gnt_o,
    output logic [NM-1:0]    rvalid_o,
    output logic [DW-1:0]    rdata_o,
    output logic [AW-1:0]    bb_addr_o,
    output logic [DW-1:0]    bb_din_o,
    output logic             bb_en_o,
    output logic             bb_we_o,
    input  logic [DW-1:0]    bb_dout_i
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t   state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic          lock_hold;

    logic [RD_LAT-1:0] rd_vld_p;
    logic [PW-1:0]     rd_id_p [RD_LAT];

    // Lock is only honoured while the owner keeps lock_i high; otherwise plain round-robin.
    always_comb begin
        int j;
        j         = 0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        lock_hold = (state_q == LOCKED) && lock_i[owner_q];
        if (!bb_rst_i) begin
            if (lock_hold) begin
                gnt_any = req_i[owner_q];
                gnt_idx = owner_q;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    j = int'(ptr_q) + k;
                    if (j >= NM) j = j - NM;
                    if (!gnt_any && req_i[j]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PW'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_o          = '0;
        gnt_o[gnt_idx] = gnt_any;
        bb_en_o        = gnt_any;
        bb_we_o        = gnt_any & we_i[gnt_idx];
        bb_addr_o      = gnt_any ? addr_i[gnt_idx*AW +: AW] : '0;
        bb_din_o       = gnt_any ? din_i[gnt_idx*DW +: DW] : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (!lock_hold) begin
            if (gnt_any && lock_i[gnt_idx]) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d = UNLOCKED;
            end
        end
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NM - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge bb_clk_i) begin
        if (bb_rst_i) begin
            state_q <= UNLOCKED;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Read return pipeline: stage 0 captures the grant, stage RD_LAT-1 meets bb_dout_i.
    always_ff @(posedge bb_clk_i) begin
        if (bb_rst_i) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= gnt_any & ~we_i[gnt_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    always_ff @(posedge bb_clk_i) begin
        rd_id_p[0] <= gnt_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_id_p[i] <= rd_id_p[i-1];
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (!bb_rst_i && rd_vld_p[RD_LAT-1]) begin
            rvalid_o[rd_id_p[RD_LAT-1]] = 1'b1;
        end
        rdata_o = bb_dout_i;
    end

endmodule

// File: tb/tb_soc_bb_sram_arbiter.sv
// Directed bench for soc_bb_sram_arbiter: vector table for grant/lock behaviour,
// hand sequences for read return, write-then-read and reset during a read.
module tb_soc_bb_sram_arbiter;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    req, we, lock;
    logic [NM*AW-1:0] addr;
    logic [NM*DW-1:0] din;
    logic [NM-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata, bb_din, bb_dout;
    logic [AW-1:0]    bb_addr;
    logic             bb_en, bb_we;

    logic             mem_load;
    logic [DW-1:0]    mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    soc_bb_sram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .bb_clk_i (clk),
        .bb_rst_i (rst),
        .req_i    (req),
        .we_i     (we),
        .lock_i   (lock),
        .addr_i   (addr),
        .din_i    (din),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .bb_addr_o(bb_addr),
        .bb_din_o (bb_din),
        .bb_en_o  (bb_en),
        .bb_we_o  (bb_we),
        .bb_dout_i(bb_dout)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM model
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h40] <= 32'hDEADBEEF;
        end else if (bb_en && bb_we) begin
            mem[bb_addr[7:0]] <= bb_din;
        end
        if (bb_en && !bb_we) bb_dout <= mem[bb_addr[7:0]];
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] we;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic [3:0] rvalid;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] w, logic [3:0] l,
                                logic [3:0] g, logic [3:0] rv);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.lock = l; v.gnt = g; v.rvalid = rv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW] = a;
        din[i*DW +: DW]  = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gi;
        rst = 1'b1; req = '0; we = '0; lock = '0; mem_load = 1'b1;
        for (int i = 0; i < NM; i++) set_port(i, AW'(16'h0100 + 4 * i), DW'(32'hA000_0000 + i));

        vecs[0]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[1]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[2]  = mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0);
        vecs[4]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
        vecs[5]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h0);
        vecs[6]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
        vecs[7]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0);
        vecs[8]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0);
        vecs[9]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h0);
        vecs[10] = mk(0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0);
        vecs[11] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[12] = mk(0, 4'hA, 4'h0, 4'h0, 4'h2, 4'h0);
        vecs[13] = mk(0, 4'hA, 4'h0, 4'h0, 4'h8, 4'h2);
        vecs[14] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
        vecs[15] = mk(0, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0);
        vecs[16] = mk(0, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0);
        vecs[17] = mk(0, 4'h1, 4'hF, 4'h1, 4'h1, 4'h0);
        vecs[18] = mk(0, 4'h8, 4'hF, 4'h1, 4'h0, 4'h0);
        vecs[19] = mk(0, 4'h8, 4'hF, 4'h1, 4'h0, 4'h0);
        vecs[20] = mk(0, 4'h9, 4'hF, 4'h1, 4'h1, 4'h0);
        vecs[21] = mk(0, 4'h9, 4'hF, 4'h0, 4'h8, 4'h0);
        vecs[22] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        for (int v = 0; v < 23; v++) begin
            next_cycle();
            if (v == 3) mem_load = 1'b0;
            rst = vecs[v].rst; req = vecs[v].req; we = vecs[v].we; lock = vecs[v].lock;
            @(negedge clk);
            chk($sformatf("gnt[%0d]", v), 64'(gnt), 64'(vecs[v].gnt));
            chk($sformatf("en[%0d]", v), 64'(bb_en), 64'(|vecs[v].gnt));
            chk($sformatf("rvalid[%0d]", v), 64'(rvalid), 64'(vecs[v].rvalid));
            gi = 0;
            for (int i = 0; i < NM; i++) if (vecs[v].gnt[i]) gi = i;
            chk($sformatf("addr[%0d]", v), 64'(bb_addr),
                (vecs[v].gnt != 0) ? 64'(16'h0100 + 4 * gi) : 64'h0);
            chk($sformatf("we[%0d]", v), 64'(bb_we),
                (vecs[v].gnt != 0) ? 64'(vecs[v].we[gi]) : 64'h0);
        end

        // Read return: requester 1 reads 0x0040
        next_cycle();
        set_port(1, 16'h0040, 32'h0); req = 4'b0010; we = 4'b0000; lock = '0;
        @(negedge clk);
        chk("rd_gnt", 64'(gnt), 64'h2);
        chk("rd_addr", 64'(bb_addr), 64'h0040);
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("rd_rvalid", 64'(rvalid), 64'h2);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);

        // Write then read by requester 2
        next_cycle();
        set_port(2, 16'h0010, 32'h12345678); req = 4'b0100; we = 4'b0100;
        @(negedge clk);
        chk("wr_gnt", 64'(gnt), 64'h4);
        chk("wr_we", 64'(bb_we), 64'h1);
        chk("wr_din", 64'(bb_din), 64'h12345678);
        next_cycle();
        we = 4'b0000;
        @(negedge clk);
        chk("wr_no_rvalid", 64'(rvalid), 64'h0);
        chk("rd2_gnt", 64'(gnt), 64'h4);
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("rd2_rvalid", 64'(rvalid), 64'h4);
        chk("rd2_rdata", 64'(rdata), 64'h12345678);

        // Reset while a read is in flight
        next_cycle();
        req = 4'b0010; we = 4'b0000;
        @(negedge clk);
        chk("rst_rd_gnt", 64'(gnt), 64'h2);
        next_cycle();
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("rst_rvalid0", 64'(rvalid), 64'h0);
        chk("rst_en", 64'(bb_en), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("rst_rvalid1", 64'(rvalid), 64'h0);
        next_cycle();
        rst = 1'b0; req = 4'hF; we = 4'hF;
        @(negedge clk);
        chk("post_rst_gnt", 64'(gnt), 64'h1);
        chk("post_rst_rvalid", 64'(rvalid), 64'h0);
        next_cycle();
        req = '0; we = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
